// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encodings and coin constants for the vending controller
package vend_pkg;

    // Two-bit registered state encoding
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CREDIT   = 2'd1;
    localparam logic [1:0] ST_DISPENSE = 2'd2;
    localparam logic [1:0] ST_CHANGE   = 2'd3;

    // Credit is counted in quarters
    localparam int unsigned QUARTER_UNITS = 1;
    localparam int unsigned DOLLAR_UNITS  = 4;

    // Four products, two-bit index
    localparam int unsigned ID_W = 2;

endpackage

// File: rtl/vend_price_lut.sv
// rtl/vend_price_lut.sv - combinational product index to price (quarters) table
module vend_price_lut
    import vend_pkg::*;
#(
    parameter int CW     = 5,
    parameter int PRICE0 = 4,
    parameter int PRICE1 = 3,
    parameter int PRICE2 = 6,
    parameter int PRICE3 = 2
) (
    input  logic [ID_W-1:0] sel_id,
    output logic [CW-1:0]   price
);

    // Price lookup; kept standalone so a product line can swap its table
    always_comb begin
        price = CW'(PRICE0);
        case (sel_id)
            2'd0:    price = CW'(PRICE0);
            2'd1:    price = CW'(PRICE1);
            2'd2:    price = CW'(PRICE2);
            2'd3:    price = CW'(PRICE3);
            default: price = CW'(PRICE0);
        endcase
    end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin credit, selection, dispense and change sequencer (optional VEND_IDLE_TIMEOUT_EN)
module vend_controller
    import vend_pkg::*;
#(
    parameter int CW          = 5,
    parameter int MAX_CREDIT  = 16,
    parameter int PRICE0      = 4,
    parameter int PRICE1      = 3,
    parameter int PRICE2      = 6,
    parameter int PRICE3      = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            quarter,
    input  logic            dollar,
    input  logic            sel_valid,
    input  logic [ID_W-1:0] sel_id,
    input  logic            cancel,
    input  logic            disp_ack,
    input  logic            chg_ack,
    output logic            disp_req,
    output logic [ID_W-1:0] disp_id,
    output logic            chg_req,
    output logic [CW-1:0]   credit,
    output logic            busy,
    output logic            coin_rej,
    output logic            sel_err
);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   credit_q, credit_d;
    logic [ID_W-1:0] disp_id_q, disp_id_d;
    logic            coin_rej_q, coin_rej_d;
    logic            sel_err_q, sel_err_d;

    logic [CW-1:0]   price;
    logic            coin_in;
    logic [CW:0]     coin_add;
    logic [CW:0]     base;
    logic [CW:0]     sum;
    logic            go_disp;
    logic            tmo_fire;

    vend_price_lut #(
        .CW     (CW),
        .PRICE0 (PRICE0),
        .PRICE1 (PRICE1),
        .PRICE2 (PRICE2),
        .PRICE3 (PRICE3)
    ) u_price_lut (
        .sel_id (sel_id),
        .price  (price)
    );

    assign coin_in  = quarter | dollar;
    assign coin_add = (dollar  ? (CW+1)'(DOLLAR_UNITS)  : '0)
                    + (quarter ? (CW+1)'(QUARTER_UNITS) : '0);

`ifdef VEND_IDLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          activity;

    assign activity = coin_in | sel_valid | cancel;
    assign tmo_fire = (state_q == ST_CREDIT) && !activity && (tmo_q == TW'(TIMEOUT_CYC - 1));

    // Idle counter runs only while holding credit with no customer activity
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_CREDIT && !activity && !tmo_fire) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign tmo_fire       = 1'b0;
`endif

    // Next-state, credit arithmetic and one-cycle status pulses
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        disp_id_d  = disp_id_q;
        coin_rej_d = 1'b0;
        sel_err_d  = 1'b0;
        base       = {1'b0, credit_q};
        sum        = {1'b0, credit_q};
        go_disp    = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                // Selection is judged on credit before any same-cycle coin
                if (sel_valid) begin
                    if (credit_q >= price) begin
                        base      = {1'b0, credit_q - price};
                        go_disp   = 1'b1;
                        disp_id_d = sel_id;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
                // A coin that would overflow the ceiling is refused whole
                sum = base + coin_add;
                if (coin_in && (sum > (CW+1)'(MAX_CREDIT))) begin
                    coin_rej_d = 1'b1;
                    sum        = base;
                end
                credit_d = sum[CW-1:0];

                if (go_disp) begin
                    state_d = ST_DISPENSE;
                end else if ((cancel || tmo_fire) && state_q == ST_CREDIT) begin
                    state_d = ST_CHANGE;
                end else begin
                    state_d = (credit_d != '0) ? ST_CREDIT : ST_IDLE;
                end
            end

            ST_DISPENSE: begin
                coin_rej_d = coin_in;
                if (disp_ack) begin
                    state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
                end
            end

            ST_CHANGE: begin
                coin_rej_d = coin_in;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (chg_ack) begin
                    credit_d = credit_q - 1'b1;
                    if (credit_q == CW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state register; reset drops every handshake at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            disp_id_q  <= '0;
            coin_rej_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            disp_id_q  <= disp_id_d;
            coin_rej_q <= coin_rej_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign disp_req = (state_q == ST_DISPENSE);
    assign chg_req  = (state_q == ST_CHANGE);
    assign busy     = disp_req | chg_req;
    assign disp_id  = disp_id_q;
    assign credit   = credit_q;
    assign coin_rej = coin_rej_q;
    assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - directed self-checking bench for vend_controller
module tb_vend_controller;

    logic       clk;
    logic       rstn;
    logic       quarter;
    logic       dollar;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       cancel;
    logic       disp_ack;
    logic       chg_ack;
    logic       disp_req;
    logic [1:0] disp_id;
    logic       chg_req;
    logic [4:0] credit;
    logic       busy;
    logic       coin_rej;
    logic       sel_err;

    int errors = 0;
    int checks = 0;

    vend_controller dut (
        .clk       (clk),
        .rstn      (rstn),
        .quarter   (quarter),
        .dollar    (dollar),
        .sel_valid (sel_valid),
        .sel_id    (sel_id),
        .cancel    (cancel),
        .disp_ack  (disp_ack),
        .chg_ack   (chg_ack),
        .disp_req  (disp_req),
        .disp_id   (disp_id),
        .chg_req   (chg_req),
        .credit    (credit),
        .busy      (busy),
        .coin_rej  (coin_rej),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1ns after the edge, pulses cleared there
    task automatic tick();
        @(posedge clk);
        #1;
        quarter   = 1'b0;
        dollar    = 1'b0;
        sel_valid = 1'b0;
        cancel    = 1'b0;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, ".disp_req"}, disp_req, 0);
        chk({tag, ".chg_req"}, chg_req, 0);
        chk({tag, ".busy"}, busy, 0);
    endtask

    initial begin
        rstn = 1'b0; quarter = 1'b0; dollar = 1'b0; sel_valid = 1'b0;
        sel_id = 2'd0; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
        tick(); tick();
        chk("rst.credit", credit, 0);
        chk("rst.coin_rej", coin_rej, 0);
        chk("rst.sel_err", sel_err, 0);
        chk("rst.disp_id", disp_id, 0);
        idle_outputs("rst");
        rstn = 1'b1;
        tick();

        // Dollar then product 0 (price 4), exact payment
        dollar = 1'b1; tick();
        chk("t1.credit", credit, 4);
        idle_outputs("t1.credit_state");
        sel_valid = 1'b1; sel_id = 2'd0; tick();
        chk("t1.disp_req", disp_req, 1);
        chk("t1.disp_id", disp_id, 0);
        chk("t1.credit_after_sel", credit, 0);
        chk("t1.busy", busy, 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        idle_outputs("t1.after_ack");
        chk("t1.credit_end", credit, 0);

        // Two dollars, product 1 (price 3), 5 quarters of change
        dollar = 1'b1; tick();
        dollar = 1'b1; tick();
        chk("t2.credit8", credit, 8);
        sel_valid = 1'b1; sel_id = 2'd1; tick();
        chk("t2.credit5", credit, 5);
        chk("t2.disp_req", disp_req, 1);
        chk("t2.disp_id", disp_id, 1);
        tick();
        chk("t2.disp_hold", disp_req, 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t2.disp_drop", disp_req, 0);
        chk("t2.chg_req", chg_req, 1);
        tick();
        chk("t2.chg_hold_credit", credit, 5);
        for (int i = 4; i >= 0; i--) begin
            chk("t2.chg_req_before_ack", chg_req, 1);
            chg_ack = 1'b1; tick();
            chk("t2.chg_credit", credit, i);
        end
        chg_ack = 1'b0;
        idle_outputs("t2.end");

        // Quarter, product 2 refused, cancel refunds 1
        quarter = 1'b1; tick();
        chk("t3.credit1", credit, 1);
        sel_valid = 1'b1; sel_id = 2'd2; tick();
        chk("t3.sel_err", sel_err, 1);
        chk("t3.credit_kept", credit, 1);
        chk("t3.no_disp", disp_req, 0);
        tick();
        chk("t3.sel_err_pulse", sel_err, 0);
        cancel = 1'b1; tick();
        chk("t3.chg_req", chg_req, 1);
        chk("t3.chg_credit", credit, 1);
        chg_ack = 1'b1; tick(); chg_ack = 1'b0;
        chk("t3.credit0", credit, 0);
        idle_outputs("t3.end");

        // Build 14 and overflow with a dollar
        for (int i = 0; i < 3; i++) begin dollar = 1'b1; tick(); end
        quarter = 1'b1; tick();
        quarter = 1'b1; tick();
        chk("t4.credit14", credit, 14);
        dollar = 1'b1; tick();
        chk("t4.coin_rej", coin_rej, 1);
        chk("t4.credit_still14", credit, 14);
        tick();
        chk("t4.coin_rej_pulse", coin_rej, 0);
        cancel = 1'b1; tick();
        chg_ack = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chg_ack = 1'b0;
        chk("t4.drained", credit, 0);
        idle_outputs("t4.drained");

        // 11 then quarter+dollar together reaches the 16 ceiling
        for (int i = 0; i < 2; i++) begin dollar = 1'b1; tick(); end
        for (int i = 0; i < 3; i++) begin quarter = 1'b1; tick(); end
        chk("t5.credit11", credit, 11);
        quarter = 1'b1; dollar = 1'b1; tick();
        chk("t5.credit16", credit, 16);
        chk("t5.no_rej", coin_rej, 0);
        quarter = 1'b1; tick();
        chk("t5.rej_at_max", coin_rej, 1);
        chk("t5.credit_max", credit, 16);

        // disp_ack outside DISPENSE is ignored
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t5.stray_ack_credit", credit, 16);
        idle_outputs("t5.stray_ack");

        // Product 3 (price 2) with same-cycle quarter: 16-2+1=15
        sel_valid = 1'b1; sel_id = 2'd3; quarter = 1'b1; tick();
        chk("t6.credit15", credit, 15);
        chk("t6.disp_id", disp_id, 3);
        chk("t6.disp_req", disp_req, 1);
        chk("t6.no_rej", coin_rej, 0);
        quarter = 1'b1; tick();
        chk("t6.rej_in_dispense", coin_rej, 1);
        chk("t6.credit_unchanged", credit, 15);
        sel_valid = 1'b1; sel_id = 2'd0; tick();
        chk("t6.sel_ignored", sel_err, 0);
        chk("t6.disp_id_stable", disp_id, 3);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t6.chg_req", chg_req, 1);
        chg_ack = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chg_ack = 1'b0;
        chk("t6.credit3", credit, 3);
        chk("t6.chg_req_mid", chg_req, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t6.rst_credit", credit, 0);
        idle_outputs("t6.rst");
        #2 rstn = 1'b1;
        tick();
        chk("t6.after_rst_credit", credit, 0);
        idle_outputs("t6.after_rst");

        // cancel together with a valid selection: selection wins
        for (int i = 0; i < 4; i++) begin quarter = 1'b1; tick(); end
        chk("t7.credit4", credit, 4);
        sel_valid = 1'b1; sel_id = 2'd0; cancel = 1'b1; tick();
        chk("t7.disp_req", disp_req, 1);
        chk("t7.chg_req", chg_req, 0);
        chk("t7.credit0", credit, 0);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        idle_outputs("t7.end");

        // cancel in IDLE is ignored
        cancel = 1'b1; tick();
        idle_outputs("t8.cancel_idle");

        // Default build has no idle timeout: credit persists
        quarter = 1'b1; tick();
        for (int i = 0; i < 100; i++) tick();
        chk("t9.credit_held", credit, 1);
        idle_outputs("t9.held");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Transaction controller that sequences a coin-operated vending slot.
- Accumulates coin credit (quarter and dollar pulses) and validates a 4-way product selection against per-product prices.
- Drives a req/ack handshake to the product dispenser, then returns change as a sequence of quarter handshakes to the coin hopper.
- Sits between the coin-acceptor front end and the dispenser/hopper actuators.

Parameters:
- CW, 5, credit register width in quarter units (25c each).
- MAX_CREDIT, 16, credit ceiling in quarters ($4.00); must be below 2**CW.
- PRICE0, 4, price of product 0 in quarters.
- PRICE1, 3, price of product 1 in quarters.
- PRICE2, 6, price of product 2 in quarters.
- PRICE3, 2, price of product 3 in quarters.
- TIMEOUT_CYC, 1000, idle-credit timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  single system clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- quarter  in  1  one-cycle pulse, 25c inserted (+1 unit).
- dollar  in  1  one-cycle pulse, $1 inserted (+4 units).
- sel_valid  in  1  one-cycle selection strobe.
- sel_id  in  2  product index, sampled with sel_valid.
- cancel  in  1  one-cycle refund request.
- disp_ack  in  1  dispenser done, level, sampled while disp_req=1.
- chg_ack  in  1  hopper ejected one quarter, sampled while chg_req=1.
- disp_req  out  1  dispense request, held until acked.
- disp_id  out  2  product to dispense, stable while disp_req=1.
- chg_req  out  1  eject one quarter per acked cycle.
- credit  out  CW  current credit in quarters.
- busy  out  1  high in DISPENSE or CHANGE.
- coin_rej  out  1  one-cycle pulse, a coin was not credited.
- sel_err  out  1  one-cycle pulse, selection refused.

Behaviour:
- Reset (async, rstn=0): state=IDLE, credit=0, all outputs 0. Credit held at reset time is discarded. Any in-flight handshake is abandoned; outputs drop immediately.
- States, registered, one-hot-free 2-bit encoding:
  - IDLE: credit==0.
  - CREDIT: credit>0.
  - DISPENSE.
  - CHANGE.
- Coins in IDLE/CREDIT:
  - add = 4*dollar + quarter.
  - If credit+add <= MAX_CREDIT, credit updates next cycle and IDLE->CREDIT.
  - Otherwise the whole add is refused, credit is unchanged, and coin_rej=1 next cycle.
- Coins in DISPENSE/CHANGE: refused, coin_rej=1 next cycle.
- Selection in IDLE/CREDIT:
  - Compared against credit before any same-cycle coin is added.
  - If credit >= PRICE[sel_id]: next cycle state=DISPENSE, disp_req=1, disp_id=sel_id, credit = credit - price + same-cycle coin add, subject to the MAX_CREDIT rule.
  - Otherwise: sel_err=1 next cycle, state unchanged, same-cycle coin still processed.
- sel_valid in DISPENSE/CHANGE: ignored, no sel_err.
- DISPENSE:
  - disp_req holds until a cycle with disp_ack=1.
  - Next cycle: disp_req=0, state=CHANGE if credit>0, else IDLE.
  - disp_ack outside DISPENSE is ignored.
- CHANGE:
  - chg_req=1.
  - Each cycle with chg_ack=1 decrements credit by 1.
  - The ack that takes credit 1->0 also deasserts chg_req next cycle and moves to IDLE.
  - chg_req never asserts with credit==0.
- cancel:
  - In CREDIT: go to CHANGE, full refund.
  - In IDLE/DISPENSE/CHANGE: ignored.
  - cancel with sel_valid in the same cycle: selection wins.
- Minimum latencies:
  - Coin to credit: 1 cycle.
  - Selection to disp_req: 1 cycle.
  - disp_ack to chg_req: 1 cycle.
- busy = (state==DISPENSE)|(state==CHANGE), registered.

Optional Feature:
- Macro: VEND_IDLE_TIMEOUT_EN.
- Defined:
  - A counter runs in CREDIT and clears on any coin, sel_valid or cancel.
  - When it reaches TIMEOUT_CYC-1, next cycle enters CHANGE (auto refund) as if cancel.
  - Counter is reset to 0 outside CREDIT.
- Undefined: no counter logic; CREDIT persists indefinitely.

Decomposition:
- Shared package vend_pkg:
  - State encodings IDLE/CREDIT/DISPENSE/CHANGE.
  - Coin unit constants (QUARTER_UNITS=1, DOLLAR_UNITS=4).
  - Product index width.
- One natural sub-module: vend_price_lut, combinational sel_id -> price from PRICE0..3. Kept separate so price tables can be swapped per product line.

Test Plan:
- Reset, then dollar pulse -> credit=4 next cycle, state CREDIT; sel_id=0 -> disp_req=1, disp_id=0, credit=0; disp_ack -> IDLE, no chg_req.
- dollar, dollar, sel_id=1 (price 3) -> credit 8->5; after disp_ack exactly 5 chg_ack cycles with chg_req high, then credit=0, IDLE.
- quarter, then sel_id=2 (price 6) -> sel_err pulse one cycle, credit stays 1; cancel -> 1 chg_req handshake, IDLE.
- Credit at 14, dollar -> coin_rej, credit=14; quarter+dollar same cycle at credit 11 -> credit 16; further quarter -> coin_rej.
- Quarter during DISPENSE -> coin_rej, credit unchanged; rstn low mid-CHANGE at credit 3 -> chg_req=0 immediately, credit=0, IDLE.
- With VEND_IDLE_TIMEOUT_EN, TIMEOUT_CYC=10: quarter then no activity for 10 cycles -> CHANGE, 1 quarter refunded. Without the macro: still CREDIT after 100 cycles.
